instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset. Ports: clk_i in 1 (clock); rst_i in 1 (async active-high reset).
REQ-002 in_valid_i  in  1  request valid.
REQ-003 in_ready_o  out  1  request accepted when in_valid_i & in_ready_o on a rising clk_i.
REQ-004 kind_i  in  3  instruction class: 0 LW, 1 SW, 2 R-type, 3 BEQ, 4 I-type ALU, 5 JAL, 6-7 invalid.
REQ-005 alu_op_i  in  3  ALU operation, used for kinds 2 and 4: 000 add, 001 sub, 101 slt, 011 or, 010 and.
REQ-006 rd_i, rs1_i, rs2_i  in  5 each  register indices.
REQ-007 imm_i  in  32  signed byte-offset or immediate.
REQ-008 out_valid_o  out  1  encoded word available.
REQ-009 out_ready_i  in  1  consumer takes the word when out_valid_o & out_ready_i.
REQ-010 instr_o  out  32  encoded RV32I word.
REQ-011 illegal_o  out  1  qualifies instr_o: the request was unencodable.
REQ-012 count_o  out  16  number of accepted requests, saturating.

Function
REQ-013 SHALL encode combinationally at the input and push {instr, illegal} into a 2-entry FIFO. out_valid_o = FIFO not empty; in_ready_o = FIFO not full.
REQ-014 Latency SHALL be 1 cycle: a word accepted at edge N is presented on instr_o after edge N.
REQ-015 instr_o and illegal_o SHALL show the FIFO head (oldest entry) and stay stable while out_valid_o=1 and out_ready_i=0.
REQ-016 Push and pop SHALL both occur in the same cycle when both are enabled. Occupancy is unchanged.
REQ-017 When full, in_ready_o SHALL be 0 even if out_ready_i=1. Push is not allowed on a full FIFO, whether or not a pop occurs.
REQ-018 A pop on an empty FIFO SHALL have no effect.
REQ-019 Encodings, with fields listed MSB to LSB:
- LW: imm[11:0] | rs1 | 010 | rd | 0000011.
- SW: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011.
- R-type: f7 | rs2 | rs1 | f3 | rd | 0110011, where f7 = 0100000 for sub and 0000000 otherwise.
- BEQ: imm[12] | imm[10:5] | rs2 | rs1 | 000 | imm[4:1] | imm[11] | 1100011.
- I-type: imm[11:0] | rs1 | f3 | rd | 0010011.
- JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111.
REQ-020 f3 mapping SHALL be: add/sub 000, slt 010, or 110, and 111.
REQ-021 illegal SHALL be 1 when any of the following holds:
- kind_i is 6 or 7.
- alu_op_i is not in REQ-005 for kind 2 or 4.
- kind 4 with sub.
- LW/SW/I-type imm is outside -2048..2047.
- BEQ imm is outside -4096..4094, or imm[0]=1.
- JAL imm is outside -1048576..1048574, or imm[0]=1.
REQ-022 When illegal=1, the stored instr SHALL be 32'h0000_0000.
REQ-023 Unused fields SHALL be ignored: rs2 for LW/I-type/JAL, rd for SW/BEQ, imm for R-type, alu_op for kinds 0, 1, 3 and 5.
REQ-024 count_o SHALL increment by 1 per accepted request, legal or illegal, and hold at 16'hFFFF.

Reset
REQ-025 While rst_i=1, asynchronously:
- FIFO empties.
- out_valid_o=0, in_ready_o=1.
- instr_o=0, illegal_o=0, count_o=0.
REQ-026 Reset asserted mid-operation SHALL discard all held words. No handshake completes on the edge where rst_i=1.
REQ-027 After rst_i deasserts, the first request SHALL be accepted on the first rising clk_i edge.

Verification
REQ-028 R-type sub with rd=3, rs1=1, rs2=2, out_ready_i=1 -> the next cycle shows instr_o=0x402081B3, illegal_o=0, count_o=1.
REQ-029 LW with rd=5, rs1=2, imm=8 -> instr_o=0x00812283. BEQ with rs1=1, rs2=2, imm=-4 -> instr_o=0xFE208EE3.
REQ-030 Boundaries:
- I-type add with imm=2048 -> illegal_o=1, instr_o=0.
- I-type add with imm=-2048 -> legal, imm field 0x800.
- BEQ with imm=6 is legal; BEQ with imm=5 is illegal.
REQ-031 out_ready_i=0 and 3 back-to-back requests -> 2 are accepted, in_ready_o=0, the third is held. out_ready_i=1 -> words drain in order, and the third is accepted on the first cycle in_ready_o returns high.
REQ-032 Full FIFO with out_ready_i=1 and in_valid_i=1 -> pop only. The next cycle accepts the push with a simultaneous pop, and occupancy stays at 1.
REQ-033 Reset pulse with 2 words held and count_o=2 -> out_valid_o=0 and count_o=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes simple instruction requests into RV32I words and
// buffers them, with an illegal flag, in a 2-entry FIFO. It also keeps a
// saturating count of accepted requests.
module instr_encoder (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [2:0]  kind_i,
   input  logic [2:0]  alu_op_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] instr_o,
   output logic        illegal_o,
   output logic [15:0] count_o
);

   logic signed [31:0] imm_s;
   logic        op_ok;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        imm12_ok;
   logic        immb_ok;
   logic        immj_ok;
   logic [31:0] enc_instr;
   logic        enc_ill;

   logic [32:0] mem_q [2];
   logic        wr_ptr_q, rd_ptr_q;
   logic [1:0]  occ_q;
   logic [15:0] count_q;
   logic        full, empty, push, pop;

   assign imm_s = imm_i;

   // Decode the ALU operation and the immediate ranges.
   always_comb begin
      op_ok = 1'b1;
      f3    = 3'b000;
      unique case (alu_op_i)
         3'b000, 3'b001: f3 = 3'b000;
         3'b101:         f3 = 3'b010;
         3'b011:         f3 = 3'b110;
         3'b010:         f3 = 3'b111;
         default:        op_ok = 1'b0;
      endcase
      f7       = (alu_op_i == 3'b001) ? 7'b0100000 : 7'b0000000;
      imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      immb_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm_i[0];
      immj_ok  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm_i[0];
   end

   // Combinational encoder; an illegal request always yields an all-zero word.
   always_comb begin
      enc_instr = 32'h0;
      enc_ill   = 1'b0;
      case (kind_i)
         3'd0: begin
            enc_instr = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
            enc_ill   = !imm12_ok;
         end
         3'd1: begin
            enc_instr = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
            enc_ill   = !imm12_ok;
         end
         3'd2: begin
            enc_instr = {f7, rs2_i, rs1_i, f3, rd_i, 7'b0110011};
            enc_ill   = !op_ok;
         end
         3'd3: begin
            enc_instr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000, imm_i[4:1],
                         imm_i[11], 7'b1100011};
            enc_ill   = !immb_ok;
         end
         3'd4: begin
            enc_instr = {imm_i[11:0], rs1_i, f3, rd_i, 7'b0010011};
            enc_ill   = !op_ok || (alu_op_i == 3'b001) || !imm12_ok;
         end
         3'd5: begin
            enc_instr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
            enc_ill   = !immj_ok;
         end
         default: enc_ill = 1'b1;
      endcase
      if (enc_ill) enc_instr = 32'h0;
   end

   assign full  = (occ_q == 2'd2);
   assign empty = (occ_q == 2'd0);
   // A full FIFO never accepts, even when it pops in the same cycle.
   assign push  = in_valid_i && !full;
   assign pop   = out_ready_i && !empty;

   // FIFO storage, pointers, occupancy and request counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         count_q  <= 16'h0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {enc_ill, enc_instr};
            wr_ptr_q        <= ~wr_ptr_q;
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         if (push && !pop)      occ_q <= occ_q + 2'd1;
         else if (pop && !push) occ_q <= occ_q - 2'd1;
      end
   end

   // Present the head entry; outputs read as zero while the FIFO is empty.
   always_comb begin
      out_valid_o = !empty;
      in_ready_o  = !full;
      count_o     = count_q;
      instr_o     = 32'h0;
      illegal_o   = 1'b0;
      if (!empty) begin
         instr_o   = mem_q[rd_ptr_q][31:0];
         illegal_o = mem_q[rd_ptr_q][32];
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [2:0]  kind_i;
   logic [2:0]  alu_op_i;
   logic [4:0]  rd_i, rs1_i, rs2_i;
   logic [31:0] imm_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] instr_o;
   logic        illegal_o;
   logic [15:0] count_o;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   always #5 clk_i = ~clk_i;

   instr_encoder dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .kind_i      (kind_i),
      .alu_op_i    (alu_op_i),
      .rd_i        (rd_i),
      .rs1_i       (rs1_i),
      .rs2_i       (rs2_i),
      .imm_i       (imm_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .instr_o     (instr_o),
      .illegal_o   (illegal_o),
      .count_o     (count_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] k, input logic [2:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
      kind_i = k; alu_op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
      in_valid_i = 1'b1;
   endtask

   // One request through an empty FIFO with the consumer ready; checks the head
   // one cycle after acceptance, which is then popped on the following edge.
   task automatic send(input string tag, input logic [2:0] k, input logic [2:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [31:0] exp_instr,
                       input logic exp_ill);
      @(negedge clk_i);
      drive(k, op, rd, rs1, rs2, imm);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      exp_cnt++;
      check({tag, ".valid"}, 32'(out_valid_o), 32'd1);
      check({tag, ".instr"}, instr_o, exp_instr);
      check({tag, ".ill"}, 32'(illegal_o), 32'(exp_ill));
      check({tag, ".cnt"}, 32'(count_o), 32'(exp_cnt));
   endtask

   initial begin
      rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
      drive(3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      in_valid_i = 1'b0;
      #12;
      check("rst.valid", 32'(out_valid_o), 32'd0);
      check("rst.ready", 32'(in_ready_o), 32'd1);
      check("rst.instr", instr_o, 32'd0);
      check("rst.ill", 32'(illegal_o), 32'd0);
      check("rst.cnt", 32'(count_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Directed encodings and legality boundaries.
      send("sub",    3'd2, 3'b001, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0);
      send("lw",     3'd0, 3'b111, 5'd5, 5'd2, 5'd9, 32'd8,        32'h00812283, 1'b0);
      send("beq-4",  3'd3, 3'b000, 5'd7, 5'd1, 5'd2, -32'sd4,      32'hFE208EE3, 1'b0);
      send("iadd2048", 3'd4, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048,   32'h0, 1'b1);
      send("iadd-2048", 3'd4, 3'b000, 5'd1, 5'd0, 5'd3, -32'sd2048, 32'h80000093, 1'b0);
      send("beq6",   3'd3, 3'b000, 5'd0, 5'd1, 5'd2, 32'd6,        32'h00208363, 1'b0);
      send("beq5",   3'd3, 3'b000, 5'd0, 5'd1, 5'd2, 32'd5,        32'h0, 1'b1);
      send("sw",     3'd1, 3'b000, 5'd9, 5'd2, 5'd5, 32'd12,       32'h00512623, 1'b0);
      send("jal",    3'd5, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF, 1'b0);
      send("or",     3'd2, 3'b011, 5'd4, 5'd5, 5'd6, 32'd77,       32'h0062E233, 1'b0);
      send("slt",    3'd2, 3'b101, 5'd1, 5'd2, 5'd3, 32'd0,        32'h003120B3, 1'b0);
      send("kind6",  3'd6, 3'b000, 5'd1, 5'd2, 5'd3, 32'd0,        32'h0, 1'b1);
      send("isub",   3'd4, 3'b001, 5'd1, 5'd2, 5'd3, 32'd1,        32'h0, 1'b1);
      send("rbadop", 3'd2, 3'b100, 5'd1, 5'd2, 5'd3, 32'd0,        32'h0, 1'b1);
      send("jalodd", 3'd5, 3'b000, 5'd1, 5'd0, 5'd0, 32'd3,        32'h0, 1'b1);

      // Backpressure: three requests, only two fit.
      @(negedge clk_i);
      out_ready_i = 1'b0;
      drive(3'd2, 3'b001, 5'd3, 5'd1, 5'd2, 32'd0);           // A = 0x402081B3
      @(negedge clk_i);
      drive(3'd0, 3'b000, 5'd5, 5'd2, 5'd0, 32'd8);           // B = 0x00812283
      @(negedge clk_i);
      drive(3'd2, 3'b011, 5'd4, 5'd5, 5'd6, 32'd0);           // C = 0x0062E233
      exp_cnt += 2;
      @(negedge clk_i);
      check("bp.ready", 32'(in_ready_o), 32'd0);
      check("bp.headA", instr_o, 32'h402081B3);
      check("bp.cnt", 32'(count_o), 32'(exp_cnt));
      @(negedge clk_i);
      check("bp.hold", instr_o, 32'h402081B3);
      check("bp.cnt2", 32'(count_o), 32'(exp_cnt));
      out_ready_i = 1'b1;                                     // full + pop: pop only
      @(negedge clk_i);
      check("bp.headB", instr_o, 32'h00812283);
      check("bp.cnt3", 32'(count_o), 32'(exp_cnt));
      check("bp.ready2", 32'(in_ready_o), 32'd1);
      @(negedge clk_i);                                       // push C with pop B
      in_valid_i = 1'b0;
      exp_cnt++;
      check("bp.headC", instr_o, 32'h0062E233);
      check("bp.cnt4", 32'(count_o), 32'(exp_cnt));
      check("bp.occ1v", 32'(out_valid_o), 32'd1);
      check("bp.occ1r", 32'(in_ready_o), 32'd1);
      @(negedge clk_i);
      check("bp.empty", 32'(out_valid_o), 32'd0);

      // Asynchronous reset with two words held.
      out_ready_i = 1'b0;
      drive(3'd0, 3'b000, 5'd5, 5'd2, 5'd0, 32'd8);
      @(negedge clk_i);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      exp_cnt += 2;
      check("ar.full", 32'(in_ready_o), 32'd0);
      check("ar.cnt", 32'(count_o), 32'(exp_cnt));
      #2 rst_i = 1'b1;
      #1;
      check("ar.valid", 32'(out_valid_o), 32'd0);
      check("ar.count", 32'(count_o), 32'd0);
      check("ar.ready", 32'(in_ready_o), 32'd1);
      check("ar.instr", instr_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      exp_cnt = 0;
      send("post-rst", 3'd0, 3'b000, 5'd5, 5'd2, 5'd0, 32'd8, 32'h00812283, 1'b0);

      // Counter saturation under continuous streaming.
      @(negedge clk_i);
      drive(3'd0, 3'b000, 5'd5, 5'd2, 5'd0, 32'd8);
      repeat (65600) @(negedge clk_i);
      check("sat.cnt", 32'(count_o), 32'hFFFF);
      @(negedge clk_i);
      check("sat.hold", 32'(count_o), 32'hFFFF);
      in_valid_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
